// File: rtl/load_store_unit.sv
// Data-memory initiator: valid/ready load/store requests, sub-word stores via
// read-modify-write, extended load data or an error flag on the response channel.
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        STORE,
        RESP
    } state_t;

    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

    state_t      state;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [1:0]  offset_q;
    logic [15:0] wdata_q;

    logic        req_err;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign mem_read   = (state == LOAD) || (state == RMW_RD);
    assign mem_write  = (state == STORE);

    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'b11)
            req_err = 1'b1;
        if ((req_size == 2'b01) && req_addr[0])
            req_err = 1'b1;
        if ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
            req_err = 1'b1;
        if ({1'b0, req_addr} >= ADDR_LIMIT)
            req_err = 1'b1;
    end

    // Little-endian lane selection from the registered low address bits
    always_comb begin
        byte_lane = mem_read_data[{offset_q, 3'b000} +: 8];
        half_lane = offset_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        load_ext  = mem_read_data;
        case (size_q)
            2'b00:   load_ext = unsigned_q ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            2'b01:   load_ext = unsigned_q ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
            default: load_ext = mem_read_data;
        endcase
    end

    always_comb begin
        merged = mem_read_data;
        if (size_q == 2'b00)
            merged[{offset_q, 3'b000} +: 8] = wdata_q[7:0];
        else if (offset_q[1])
            merged[31:16] = wdata_q;
        else
            merged[15:0] = wdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            size_q         <= '0;
            unsigned_q     <= 1'b0;
            offset_q       <= '0;
            wdata_q        <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
            resp_rdata     <= '0;
            resp_error     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        offset_q   <= req_addr[1:0];
                        wdata_q    <= req_wdata[15:0];
                        if (req_err) begin
                            resp_error <= 1'b1;
                            resp_rdata <= '0;
                            state      <= RESP;
                        end else begin
                            mem_address <= {req_addr[31:2], 2'b00};
                            if (!req_write) begin
                                state <= LOAD;
                            end else if (req_size == 2'b10) begin
                                mem_write_data <= req_wdata;
                                state          <= STORE;
                            end else begin
                                state <= RMW_RD;
                            end
                        end
                    end
                end
                LOAD: begin
                    resp_rdata <= load_ext;
                    resp_error <= 1'b0;
                    state      <= RESP;
                end
                // The merged word is the merge register; it drives memory in STORE
                RMW_RD: begin
                    mem_write_data <= merged;
                    state          <= STORE;
                end
                STORE: begin
                    resp_rdata <= '0;
                    resp_error <= 1'b0;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface. Accepts load/store requests from the CPU execute stage over a valid/ready handshake and drives mem_read, mem_write, mem_address and mem_write_data into data memory.
- Handles byte, halfword and word accesses. Sub-word stores use read-modify-write, because data memory writes whole words only.
- Returns sign- or zero-extended load data, or an error flag, over a valid/ready response channel.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in data memory. Byte addresses at or above MEM_WORDS*4 are out of range.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request; high only in IDLE
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, taken from the low bits for sub-word sizes
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts the response
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_error  output  1  misaligned access, out-of-range address or illegal size
- mem_read  output  1  memory read enable; memory read data is combinational in the same cycle
- mem_write  output  1  memory write enable; memory writes on the rising edge of clk
- mem_address  output  32  word-aligned byte address, bits [1:0] always 0
- mem_write_data  output  32  full word to write
- mem_read_data  input  32  word returned by memory

Behaviour:
- States: IDLE, LOAD, RMW_RD, STORE, RESP.
- Reset (asynchronous, immediate):
  - state goes to IDLE.
  - All request/response registers clear to 0.
  - mem_read=0, mem_write=0, mem_address=0, mem_write_data=0, resp_valid=0, resp_rdata=0, resp_error=0, req_ready=1.
  - Reset mid-operation abandons the operation. A pending STORE write is dropped if rst is asserted before its clock edge. No response is produced.
- mem_read and mem_write are decoded from the state register only.
  - mem_read=1 in LOAD and RMW_RD.
  - mem_write=1 in STORE.
  - Outside those states both are 0, and mem_address / mem_write_data hold their last values.
- IDLE: req_ready=1. When req_valid=1, register the request and check it.
  - Error if any of: size 11; halfword with addr[0]=1; word with addr[1:0]!=0; addr >= MEM_WORDS*4.
  - Error → RESP with resp_error=1. No memory access occurs.
  - Valid load → LOAD.
  - Valid word store → STORE.
  - Valid byte or halfword store → RMW_RD.
- LOAD (1 cycle): mem_read=1, mem_address={addr[31:2],2'b00}.
  - At the clock edge, select the lane (little-endian: byte lane = addr[1:0], halfword lane = addr[1]).
  - Extend per req_unsigned, latch into resp_rdata, go to RESP.
- RMW_RD (1 cycle): mem_read=1. Latch mem_read_data into the merge register, go to STORE.
- STORE (1 cycle): mem_write=1.
  - Word store: mem_write_data = req_wdata.
  - Sub-word store: mem_write_data = merge register with the addressed byte/halfword lane replaced by req_wdata[7:0] or [15:0].
  - Next state RESP with resp_rdata=0, resp_error=0.
- RESP: resp_valid=1, outputs held stable until resp_ready=1. Then go to IDLE. A new request is accepted on the following cycle, not the same one.
- Latency from request acceptance to resp_valid:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- Exactly one memory write per accepted valid store. No write for loads or errors.
- req_valid is ignored outside IDLE. The requester holds its request until req_ready=1.

Test Plan:
- Reset check: assert rst mid-cycle with no clock edge → all outputs reach reset values immediately, req_ready=1.
- Word store then load: store addr 0x10, data 0xDEADBEEF → mem_write for exactly 1 cycle with mem_address=0x10; then a word load from 0x10 → resp_rdata=0xDEADBEEF, resp_error=0, resp_valid 2 cycles after acceptance.
- Byte RMW and extension: memory word at 0x20 = 0x11223344; byte store 0xAB to 0x22 → one read cycle, then a write of 0x11AB3344. Byte load 0x22 signed → 0xFFFFFFAB; unsigned → 0x000000AB.
- Halfword: signed halfword load from 0x22 of word 0x80017FFF → 0xFFFF8001.
- Errors, each giving resp_error=1 after 1 cycle with mem_read=mem_write=0 throughout:
  - halfword at 0x23
  - word at 0x12
  - size=11
  - address 0x1000 with MEM_WORDS=1024
- Backpressure and reset mid-store:
  - Hold resp_ready=0 for 5 cycles → resp_valid and resp_rdata stable, req_ready=0.
  - Assert rst during RMW_RD → memory contents unchanged, no response produced.
